divider_iterative: RTL

Sequential radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the responder on the execute-stage start/done handshake that the multiplier controller already drives toward the iterative multiplier. It replaces the combinational divider on that handshake. One quotient bit is produced per cycle, and the block reports busy to the controller and hazard logic until the result is ready.

---
 rtl/divider_iterative.sv | 104 ++++++++++
 1 files changed

// File: rtl/divider_iterative.sv
// divider_iterative: radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, define DIV_EARLY_OUT_EN for early divide-by-zero/overflow completion
module divider_iterative (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [1:0]  div_opcode,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic [31:0] result_divide,
  output logic        done,
  output logic        div_use
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic        sel_rem, neg1, neg2, div_zero, ovf;
  logic [31:0] rem, quo, divisor;
  logic [4:0]  cnt;
  logic        is_signed, accept, in_neg1, in_neg2, in_zero, in_ovf, ge;
  logic [31:0] mag1, mag2, q_fix, r_fix, fixed, early;
  logic [32:0] shifted;
  // accept decode, operand magnitudes, one restoring step and the sign/special-case fix-up
  always_comb begin
    is_signed = ~div_opcode[0];
    accept    = startE & (state == IDLE | state == DONE);
    in_neg1   = is_signed & operand1[31];
    in_neg2   = is_signed & operand2[31];
    mag1      = in_neg1 ? -operand1 : operand1;
    mag2      = in_neg2 ? -operand2 : operand2;
    in_zero   = operand2 == 32'h0;
    in_ovf    = is_signed & operand1 == 32'h8000_0000 & operand2 == 32'hFFFF_FFFF;
    early     = in_zero ? (div_opcode[1] ? operand1 : 32'hFFFF_FFFF) : (div_opcode[1] ? 32'h0 : 32'h8000_0000);
    shifted   = {rem, quo[31]};
    ge        = shifted >= {1'b0, divisor};
    q_fix     = div_zero ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : (neg1 ^ neg2) ? -quo : quo;
    r_fix     = ovf ? 32'h0 : neg1 ? -rem : rem;
    fixed     = sel_rem ? r_fix : q_fix;
  end
  // control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel_rem       <= 1'b0;
      neg1          <= 1'b0;
      neg2          <= 1'b0;
      div_zero      <= 1'b0;
      ovf           <= 1'b0;
      rem           <= '0;
      quo           <= '0;
      divisor       <= '0;
      cnt           <= '0;
      result_divide <= '0;
      done          <= 1'b0;
      div_use       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sel_rem  <= div_opcode[1];
        neg1     <= in_neg1;
        neg2     <= in_neg2;
        div_zero <= in_zero;
        ovf      <= in_ovf;
        rem      <= '0;
        quo      <= mag1;
        divisor  <= mag2;
        cnt      <= 5'd31;
        div_use  <= 1'b1;
`ifdef DIV_EARLY_OUT_EN
        if (in_zero | in_ovf) begin
          state         <= DONE;
          done          <= 1'b1;
          result_divide <= early;
        end else begin
          state <= CALC;
        end
`else
        state <= CALC;
`endif
      end else begin
        case (state)
          CALC: begin
            rem   <= ge ? 32'(shifted - {1'b0, divisor}) : shifted[31:0];
            quo   <= {quo[30:0], ge};
            cnt   <= cnt - 5'd1;
            state <= cnt == 5'd0 ? FIX : CALC;
          end
          FIX: begin
            state         <= DONE;
            done          <= 1'b1;
            result_divide <= fixed;
          end
          DONE: begin
            state   <= IDLE;
            div_use <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifndef DIV_EARLY_OUT_EN
  logic unused_early;
  assign unused_early = ^early;
`endif
endmodule
